// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one SRAM controller between two requesting ports.
//
// Parameters
//   PRIO_MODE : 0 = round-robin on ties, 1 = fixed priority (port 0 wins ties)
//   TIMEOUT   : maximum number of BUSY cycles an access may run (1..255)
//
// Ports
//   clk, rst                      : clock, asynchronous active-high reset
//   pX_wr_en / pX_rd_en           : port X request levels (write wins if both)
//   pX_addr / pX_wdata            : port X address and write data
//   pX_rdata / pX_ready           : port X read data and completion/idle flag
//   mem_wr_en / mem_rd_en         : enables towards the SRAM controller
//   mem_addr / mem_wdata          : forwarded address and write data
//   mem_rdata / mem_ready         : controller read data and ready
//   grant                         : one-hot current owner (00 = none)
//   timeout_err                   : sticky flag set when an access is aborted
module sram_port_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_wr_en,
    input  logic        p0_rd_en,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic [63:0] p0_rdata,
    output logic        p0_ready,
    input  logic        p1_wr_en,
    input  logic        p1_rd_en,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic [63:0] p1_rdata,
    output logic        p1_ready,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, RELEASE} state_t;

    localparam logic       FIXED_PRIO    = (PRIO_MODE == 1);
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);

    state_t      state, state_next;
    logic        last_grant, last_grant_next;
    logic [7:0]  wdog, wdog_next;
    logic        set_timeout;
    logic        completion;
    logic [63:0] p0_rdata_q, p1_rdata_q;

    logic req0, req1;
    logic sel_p1;
    logic sel_wr, sel_rd, sel_req;
    logic [31:0] sel_addr, sel_wdata;

    assign req0 = p0_wr_en | p0_rd_en;
    assign req1 = p1_wr_en | p1_rd_en;

    // Mux of the port that owns the controller while in a BUSY state
    assign sel_p1    = (state == BUSY1);
    assign sel_wr    = sel_p1 ? p1_wr_en  : p0_wr_en;
    assign sel_rd    = sel_p1 ? p1_rd_en  : p0_rd_en;
    assign sel_req   = sel_p1 ? req1      : req0;
    assign sel_addr  = sel_p1 ? p1_addr   : p0_addr;
    assign sel_wdata = sel_p1 ? p1_wdata  : p0_wdata;

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        wdog_next       = wdog;
        set_timeout     = 1'b0;
        completion      = 1'b0;
        grant           = 2'b00;
        mem_wr_en       = 1'b0;
        mem_rd_en       = 1'b0;
        mem_addr        = 32'h0;
        mem_wdata       = 32'h0;

        case (state)
            IDLE: begin
                // Every BUSY entry comes from IDLE, so clearing here clears on entry.
                wdog_next = 8'h00;
                // last_grant == 1 means port 1 owned last, so port 0 wins a tie.
                if (req0 && (!req1 || FIXED_PRIO || last_grant)) begin
                    state_next      = BUSY0;
                    last_grant_next = 1'b0;
                end else if (req1) begin
                    state_next      = BUSY1;
                    last_grant_next = 1'b1;
                end
            end
            BUSY0, BUSY1: begin
                grant      = sel_p1 ? 2'b10 : 2'b01;
                mem_wr_en  = sel_wr;
                mem_rd_en  = sel_rd & ~sel_wr;
                mem_addr   = sel_addr;
                mem_wdata  = sel_wdata;
                completion = (mem_wr_en | mem_rd_en) & mem_ready;
                wdog_next  = wdog + 8'd1;
                // A dropped request releases quietly; the watchdog only fires
                // once TIMEOUT BUSY cycles have passed with no completion.
                if (completion || !sel_req) begin
                    state_next = RELEASE;
                end else if (wdog_next == TIMEOUT_LIMIT) begin
                    state_next  = RELEASE;
                    set_timeout = 1'b1;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            wdog        <= 8'h00;
            timeout_err <= 1'b0;
            p0_rdata_q  <= 64'h0;
            p1_rdata_q  <= 64'h0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            wdog       <= wdog_next;
            if (set_timeout) begin
                timeout_err <= 1'b1;
            end
            if (grant[0] && completion) begin
                p0_rdata_q <= mem_rdata;
            end
            if (grant[1] && completion) begin
                p1_rdata_q <= mem_rdata;
            end
        end
    end

    // Read data passes straight through in the completion cycle, then holds.
    assign p0_rdata = (grant[0] && completion) ? mem_rdata : p0_rdata_q;
    assign p1_rdata = (grant[1] && completion) ? mem_rdata : p1_rdata_q;

    // An idle port reads as ready; a requester only sees ready on completion.
    assign p0_ready = ~req0 | (grant[0] & completion);
    assign p1_ready = ~req1 | (grant[1] & completion);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter. Two instances share all stimulus:
// dut_rr (round-robin) and dut_fp (fixed priority), both with TIMEOUT=10.
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_wr_en, p0_rd_en, p1_wr_en, p1_rd_en;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;

    logic [63:0] a_p0_rdata, a_p1_rdata, b_p0_rdata, b_p1_rdata;
    logic        a_p0_ready, a_p1_ready, b_p0_ready, b_p1_ready;
    logic        a_mem_wr_en, a_mem_rd_en, b_mem_wr_en, b_mem_rd_en;
    logic [31:0] a_mem_addr, a_mem_wdata, b_mem_addr, b_mem_wdata;
    logic [1:0]  a_grant, b_grant;
    logic        a_timeout_err, b_timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    sram_port_arbiter #(.PRIO_MODE(0), .TIMEOUT(10)) dut_rr (
        .clk(clk), .rst(rst),
        .p0_wr_en(p0_wr_en), .p0_rd_en(p0_rd_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(a_p0_rdata), .p0_ready(a_p0_ready),
        .p1_wr_en(p1_wr_en), .p1_rd_en(p1_rd_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(a_p1_rdata), .p1_ready(a_p1_ready),
        .mem_wr_en(a_mem_wr_en), .mem_rd_en(a_mem_rd_en),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(a_grant), .timeout_err(a_timeout_err)
    );

    sram_port_arbiter #(.PRIO_MODE(1), .TIMEOUT(10)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_wr_en(p0_wr_en), .p0_rd_en(p0_rd_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(b_p0_rdata), .p0_ready(b_p0_ready),
        .p1_wr_en(p1_wr_en), .p1_rd_en(p1_rd_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(b_p1_rdata), .p1_ready(b_p1_ready),
        .mem_wr_en(b_mem_wr_en), .mem_rd_en(b_mem_rd_en),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(b_grant), .timeout_err(b_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs sampled on falling edges.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        p0_wr_en = 0; p0_rd_en = 0; p1_wr_en = 0; p1_rd_en = 0;
        p0_addr = 0; p0_wdata = 0; p1_addr = 0; p1_wdata = 0;
        mem_rdata = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        p0_rd_en = 1'b1;
        p0_addr  = 32'h10;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (a_grant !== 2'b00 || a_mem_wr_en !== 1'b0 || a_mem_rd_en !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_outputs: grant=%b wr=%b rd=%b, required 00 0 0", a_grant, a_mem_wr_en, a_mem_rd_en);
        end
        n_checks++;
        if (a_timeout_err !== 1'b0 || a_p0_rdata !== 64'h0 || a_p1_rdata !== 64'h0) begin
            n_errors++;
            $display("[TB] FAIL reset_regs: terr=%b p0_rdata=%h p1_rdata=%h, required 0 0 0", a_timeout_err, a_p0_rdata, a_p1_rdata);
        end
        n_checks++;
        if (a_p0_ready !== 1'b0 || a_p1_ready !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL reset_ready: p0_ready=%b p1_ready=%b, required 0 1", a_p0_ready, a_p1_ready);
        end
        n_checks++;
        if (a_mem_addr !== 32'h0) begin
            n_errors++;
            $display("[TB] FAIL reset_addr: mem_addr=%h, required 0", a_mem_addr);
        end
        do_reset();
    endtask

    task automatic test_read();
        do_reset();
        p0_rd_en  = 1'b1;
        p0_addr   = 32'h400;
        mem_rdata = 64'h1122334455667788;
        @(negedge clk);
        n_checks++;
        if (a_mem_rd_en !== 1'b0 || a_grant !== 2'b00 || a_p0_ready !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL read_t0: rd=%b grant=%b ready=%b, required 0 00 0", a_mem_rd_en, a_grant, a_p0_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (a_mem_rd_en !== 1'b1 || a_mem_wr_en !== 1'b0 || a_grant !== 2'b01 ||
                a_mem_addr !== 32'h400 || a_p0_ready !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL read_busy_t%0d: rd=%b wr=%b grant=%b addr=%h ready=%b, required 1 0 01 400 0",
                         k, a_mem_rd_en, a_mem_wr_en, a_grant, a_mem_addr, a_p0_ready);
            end
        end
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_p0_ready !== 1'b1 || a_p0_rdata !== 64'h1122334455667788 || a_grant !== 2'b01) begin
            n_errors++;
            $display("[TB] FAIL read_t6: ready=%b rdata=%h grant=%b, required 1 1122334455667788 01", a_p0_ready, a_p0_rdata, a_grant);
        end
        tick();
        p0_rd_en  = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 64'hFFFF0000FFFF0000;
        @(negedge clk);
        n_checks++;
        if (a_grant !== 2'b00 || a_mem_rd_en !== 1'b0 || a_mem_addr !== 32'h0) begin
            n_errors++;
            $display("[TB] FAIL read_release: grant=%b rd=%b addr=%h, required 00 0 0", a_grant, a_mem_rd_en, a_mem_addr);
        end
        n_checks++;
        if (a_p0_rdata !== 64'h1122334455667788 || a_p0_ready !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL read_hold: rdata=%h ready=%b, required 1122334455667788 1", a_p0_rdata, a_p0_ready);
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_rr [12];
        logic [1:0] exp_fp [12];
        logic [31:0] exp_addr;
        exp_rr = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
        exp_fp = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        do_reset();
        p0_rd_en  = 1'b1;
        p0_addr   = 32'h100;
        p1_rd_en  = 1'b1;
        p1_addr   = 32'h200;
        mem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            exp_addr = (exp_rr[i] == 2'b01) ? 32'h100 : (exp_rr[i] == 2'b10) ? 32'h200 : 32'h0;
            n_checks++;
            if (a_grant !== exp_rr[i] || a_mem_rd_en !== (exp_rr[i] != 2'b00) || a_mem_addr !== exp_addr) begin
                n_errors++;
                $display("[TB] FAIL rr_cycle%0d: grant=%b rd=%b addr=%h, required %b %b %h",
                         i, a_grant, a_mem_rd_en, a_mem_addr, exp_rr[i], (exp_rr[i] != 2'b00), exp_addr);
            end
            n_checks++;
            if (b_grant !== exp_fp[i] || b_mem_rd_en !== (exp_fp[i] != 2'b00) || b_p1_ready !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL fp_cycle%0d: grant=%b rd=%b p1_ready=%b, required %b %b 0",
                         i, b_grant, b_mem_rd_en, b_p1_ready, exp_fp[i], (exp_fp[i] != 2'b00));
            end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_write_priority();
        do_reset();
        p1_wr_en  = 1'b1;
        p1_rd_en  = 1'b1;
        p1_addr   = 32'h80;
        p1_wdata  = 32'hDEADBEEF;
        tick();
        @(negedge clk);
        n_checks++;
        if (a_grant !== 2'b10 || a_mem_wr_en !== 1'b1 || a_mem_rd_en !== 1'b0 ||
            a_mem_wdata !== 32'hDEADBEEF || a_mem_addr !== 32'h80) begin
            n_errors++;
            $display("[TB] FAIL write_fwd: grant=%b wr=%b rd=%b wdata=%h addr=%h, required 10 1 0 deadbeef 80",
                     a_grant, a_mem_wr_en, a_mem_rd_en, a_mem_wdata, a_mem_addr);
        end
        n_checks++;
        if (a_p1_ready !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL write_wait: p1_ready=%b, required 0", a_p1_ready);
        end
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_p1_ready !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL write_done: p1_ready=%b, required 1", a_p1_ready);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (a_grant !== 2'b00 || a_mem_wr_en !== 1'b0 || a_mem_wdata !== 32'h0) begin
            n_errors++;
            $display("[TB] FAIL write_release: grant=%b wr=%b wdata=%h, required 00 0 0", a_grant, a_mem_wr_en, a_mem_wdata);
        end
    endtask

    task automatic test_drop_request();
        do_reset();
        p0_rd_en = 1'b1;
        p0_addr  = 32'h44;
        tick();
        @(negedge clk);
        n_checks++;
        if (a_grant !== 2'b01 || a_mem_rd_en !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL drop_busy: grant=%b rd=%b, required 01 1", a_grant, a_mem_rd_en);
        end
        tick();
        p0_rd_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_mem_rd_en !== 1'b0 || a_grant !== 2'b01) begin
            n_errors++;
            $display("[TB] FAIL drop_same_cycle: rd=%b grant=%b, required 0 01", a_mem_rd_en, a_grant);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (a_grant !== 2'b00 || a_timeout_err !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL drop_release: grant=%b terr=%b, required 00 0", a_grant, a_timeout_err);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        p0_wr_en = 1'b1;
        p0_addr  = 32'h500;
        p0_wdata = 32'h55;
        for (int k = 1; k <= 10; k++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (a_grant !== 2'b01 || a_mem_wr_en !== 1'b1 || a_p0_ready !== 1'b0 || a_timeout_err !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL timeout_busy%0d: grant=%b wr=%b ready=%b terr=%b, required 01 1 0 0",
                         k, a_grant, a_mem_wr_en, a_p0_ready, a_timeout_err);
            end
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (a_grant !== 2'b00 || a_mem_wr_en !== 1'b0 || a_timeout_err !== 1'b1 || a_p0_ready !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL timeout_abort: grant=%b wr=%b terr=%b ready=%b, required 00 0 1 0",
                     a_grant, a_mem_wr_en, a_timeout_err, a_p0_ready);
        end
        tick();
        p0_wr_en = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if (a_timeout_err !== 1'b1 || b_timeout_err !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL timeout_sticky: rr=%b fp=%b, required 1 1", a_timeout_err, b_timeout_err);
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if (a_timeout_err !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL timeout_cleared: terr=%b, required 0", a_timeout_err);
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        p1_rd_en = 1'b1;
        p1_addr  = 32'h900;
        tick();
        @(negedge clk);
        n_checks++;
        if (a_grant !== 2'b10 || a_mem_rd_en !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL midrst_busy: grant=%b rd=%b, required 10 1", a_grant, a_mem_rd_en);
        end
        #2;
        rst      = 1'b1;
        p0_rd_en = 1'b1;
        p0_addr  = 32'h300;
        #1;
        n_checks++;
        if (a_grant !== 2'b00 || a_mem_rd_en !== 1'b0 || a_mem_addr !== 32'h0 || a_p1_ready !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL midrst_async: grant=%b rd=%b addr=%h p1_ready=%b, required 00 0 0 0",
                     a_grant, a_mem_rd_en, a_mem_addr, a_p1_ready);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_grant !== 2'b00) begin
            n_errors++;
            $display("[TB] FAIL midrst_idle: grant=%b, required 00", a_grant);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (a_grant !== 2'b01 || a_mem_addr !== 32'h300) begin
            n_errors++;
            $display("[TB] FAIL midrst_tie: grant=%b addr=%h, required 01 300", a_grant, a_mem_addr);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_read();
        test_arbitration();
        test_write_priority();
        test_drop_request();
        test_timeout();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter PRIO_MODE, default 0, meaning 0 = round-robin and 1 = fixed priority with port 0 winning.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles a granted access may run before it is aborted (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have ports p0_wr_en and p0_rd_en, input, 1 bit each: port 0 request levels, held until p0_ready.
REQ-006 SHALL have ports p0_addr and p0_wdata, input, 32 bits each: port 0 address and write data, stable while requesting.
REQ-007 SHALL have ports p0_rdata (output, 64 bits) and p0_ready (output, 1 bit): port 0 read data and completion/idle flag.
REQ-008 SHALL have ports p1_wr_en, p1_rd_en, p1_addr, p1_wdata, p1_rdata and p1_ready, with the same widths and meanings as port 0.
REQ-009 SHALL have ports mem_wr_en and mem_rd_en, output, 1 bit each: enables to the shared SRAM controller.
REQ-010 SHALL have ports mem_addr and mem_wdata, output, 32 bits each: forwarded address and write data.
REQ-011 SHALL have ports mem_rdata (input, 64 bits) and mem_ready (input, 1 bit): controller read data and ready.
REQ-012 SHALL have port grant, output, 2 bits, one-hot: the current owner (bit0 = p0, bit1 = p1, 00 = none).
REQ-013 SHALL have port timeout_err, output, 1 bit: sticky flag marking an aborted access.

Function
REQ-014 SHALL treat a port as requesting when wr_en|rd_en; when both are asserted, only the write is forwarded.
REQ-015 SHALL implement the FSM states IDLE, BUSY0, BUSY1 and RELEASE.
REQ-016 SHALL, in IDLE, go to BUSY0/BUSY1 on the next edge when the corresponding port wins arbitration, and stay in IDLE when there is no request.
REQ-017 SHALL arbitrate with PRIO_MODE=0 as follows: a single requester wins; with two requesters, the port other than last_grant wins.
REQ-018 SHALL update last_grant on entry to BUSYx; its reset value is 1, so p0 wins the first tie.
REQ-019 SHALL arbitrate with PRIO_MODE=1 by letting p0 always win a tie.
REQ-020 SHALL, in BUSYx, drive grant from the state and forward port x's enables, addr and wdata combinationally to mem_*.
REQ-021 SHALL detect completion in BUSYx as the cycle with (mem_wr_en|mem_rd_en) && mem_ready.
REQ-022 SHALL, in the completion cycle: px_ready=1, px_rdata=mem_rdata, and go to RELEASE on the next edge.
REQ-023 SHALL, in RELEASE, hold mem enables 0 and grant 00, then go to IDLE after exactly 1 cycle, so the controller sees a dead cycle between accesses.
REQ-024 SHALL have a request-to-enable latency of 1 cycle, and a minimum spacing of 2 dead cycles from the completion cycle to the next mem enable.
REQ-025 SHALL drive px_ready = ~(px_wr_en|px_rd_en) | (grant[x] && completion); a non-granted requester sees px_ready=0.
REQ-026 SHALL hold px_rdata registered as the value captured at the port's last completion (reset 0).
REQ-027 SHALL, when the granted port drops its request in BUSYx before completion, drop mem enables in that cycle, go to RELEASE and not assert timeout_err.
REQ-028 SHALL run an 8-bit watchdog counter that clears on entry to BUSYx and increments each BUSYx cycle.
REQ-029 SHALL, when the watchdog reaches TIMEOUT without completion: go to RELEASE, set timeout_err=1 (sticky until rst) and keep px_ready=0, so the requester stays frozen.
REQ-030 SHALL drive mem_addr and mem_wdata to 0 when grant=00.
REQ-031 SHALL ignore mem_ready outside BUSYx.

Reset
REQ-032 SHALL, on rst (any time, including mid-BUSYx), go immediately to: state IDLE, mem_wr_en=0, mem_rd_en=0, grant=00, last_grant=1, watchdog=0, timeout_err=0, p0_rdata=p1_rdata=0.
REQ-033 SHALL drive, while in reset, px_ready = ~(px_wr_en|px_rd_en).
REQ-034 SHALL start the first arbitration on the first rising edge after rst deasserts.

Verification
REQ-035 SHALL verify: p0 read at addr 0x400, controller completes after 6 cycles with data 0x1122334455667788 -> mem_rd_en at t+1, p0_ready pulse at t+6, p0_rdata holds the value, grant 01 then 00.
REQ-036 SHALL verify: p0 and p1 requesting continuously with PRIO_MODE=0 -> grants alternate p0, p1, p0, p1, with 2 dead cycles between enables.
REQ-037 SHALL verify: the same stimulus with PRIO_MODE=1 -> p0 granted every time and p1 starved.
REQ-038 SHALL verify: p1 asserts wr_en and rd_en together with wdata 0xDEADBEEF -> only mem_wr_en is asserted and mem_wdata=0xDEADBEEF.
REQ-039 SHALL verify: mem_ready held 0 with TIMEOUT=10 -> abort after 10 BUSY cycles, timeout_err=1, p0_ready stays 0, and timeout_err persists until rst.
REQ-040 SHALL verify: rst pulsed during BUSY1 -> mem enables drop in the same cycle, grant=00, and p0 (tie after reset) wins the next arbitration.
